multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. Steps one instruction at a time through fetch, decode, execute, memory and writeback, driving the shared datapath and the single unified memory port. Control encodings match the core's single-cycle opcode decoder, so the ALU control and datapath muxes are reused unchanged. Also counts retired instructions and traps on illegal opcodes.

## Interface
Parameters:
- RETIRE_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  instruction[6:0] from the instruction register; stable from DECODE onward
- mem_ready  in  1  memory ack; sampled only in FETCH and MEM
- taken  in  1  branch comparison result from the ALU; sampled only in EXEC of a branch
- mem_req  out  1  memory access request
- mem_we  out  1  store strobe; valid with mem_req
- i_or_d  out  1  address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  load the instruction register and old-PC register
- pc_write  out  1  update PC
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = JAL target, 11 = JALR target
- alu_op  out  2  00 = add, 01 = branch compare, 10 = R funct, 11 = I funct
- alu_src  out  1  0 = rs2, 1 = immediate
- mem_to_reg  out  1  writeback selects memory data
- link  out  1  writeback selects old-PC+4 (JAL/JALR)
- reg_write  out  1  register-file write enable
- instr_retired  out  1  one-cycle pulse per completed instruction
- retired  out  RETIRE_W  retired-instruction count
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are unreachable and recover to FETCH.
- Instruction class decoded from opcode:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - JAL = 1101111
  - JALR = 1100111
  - any other value is ILLEGAL
- The class is latched in DECODE and used by all later states.
- Outputs are decoded from state and latched class. Every output not listed for a state is 0.
- FETCH: mem_req=1, i_or_d=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise stay in FETCH.
- DECODE: latch the class. Legal class goes to EXEC. ILLEGAL behaviour is set under Configuration.
- EXEC, alu_src: 1 for I, LOAD, STORE, JAL, JALR; 0 for R and BRANCH.
- EXEC, alu_op: 10 for R; 11 for I, JAL, JALR; 00 for LOAD and STORE; 01 for BRANCH.
- EXEC, next state:
  - R, I: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: pc_write=taken, pc_src=01, instr_retired=1, go to FETCH.
  - JAL: pc_write=1, pc_src=10, go to WB.
  - JALR: pc_write=1, pc_src=11, go to WB.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for STORE. Hold until mem_ready=1. Then LOAD goes to WB; STORE asserts instr_retired and goes to FETCH.
- WB: reg_write=1, mem_to_reg=1 for LOAD, link=1 for JAL/JALR, instr_retired=1, go to FETCH.
- TRAP: all datapath and memory outputs 0, illegal=1. Left only by reset.
- retired increments on every instr_retired pulse and wraps from all-ones to 0.
- mem_ready in any state other than FETCH or MEM is ignored.

## Timing
- Reset values: state=FETCH, retired=0, illegal=0, latched class=R.
- While reset is high, every output is forced to 0, including mem_req.
- Reset asserted mid-operation abandons any pending memory request immediately. The memory must tolerate mem_req dropping without an ack.
- First mem_req appears in the first cycle after reset deasserts.
- Cycles per instruction with mem_ready tied high: R 4, I 4, LOAD 5, STORE 4, BRANCH 3, JAL 4, JALR 4.
- Each cycle mem_ready stays low in FETCH or MEM adds one cycle.
- instr_retired is asserted in the last cycle of the instruction. retired shows the new count one cycle later.
- Branch: pc_write and the FETCH transition occur in the same EXEC cycle. A not-taken branch leaves PC at the PC+4 written in FETCH.

## Configuration
- CTRL_TRAP_EN defined: an ILLEGAL class in DECODE goes to TRAP, and illegal rises on the next cycle. instr_retired is not pulsed; retired is frozen.
- CTRL_TRAP_EN undefined: ILLEGAL is executed as a NOP. DECODE pulses instr_retired and returns to FETCH (2 cycles total); illegal is tied to 0 and TRAP is unreachable.

## Test plan
- Reset, then opcode=0110011 with mem_ready=1 → states 0,1,2,4,0; reg_write=1 only in WB; alu_op=10, alu_src=0 in EXEC; retired=1.
- LOAD with mem_ready low for 3 cycles in MEM → mem_req=1, i_or_d=1 held 4 cycles; WB has mem_to_reg=1; 8 cycles total.
- BRANCH with taken=1, then again with taken=0 → EXEC pc_write=1, pc_src=01 for the first and pc_write=0 for the second; 3 cycles each; retired=2.
- JALR → EXEC pc_write=1, pc_src=11, alu_src=1; WB link=1, reg_write=1.
- opcode=0000000 with CTRL_TRAP_EN → state 5, illegal=1, outputs 0, retired unchanged for 20 cycles. Without the macro → back to FETCH after 2 cycles, retired+1.
- Reset asserted during MEM of a STORE → mem_req and mem_we drop the same cycle; after release, state=0 and retired=0. Also preload retired to all-ones via 2^RETIRE_W retirements with RETIRE_W=4 → wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: unified memory port between the multi-cycle controller and memory
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;
    modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
    modport slave (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer (fetch/decode/exec/mem/wb), retire counter, illegal-opcode trap when CTRL_TRAP_EN is defined
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus,
    input  logic [6:0]          opcode,
    input  logic                taken,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_op,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                link,
    output logic                reg_write,
    output logic                instr_retired,
    output logic [RETIRE_W-1:0] retired,
    output logic                illegal,
    output logic [2:0]          state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILL
    } cls_t;

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;

    // classify the opcode held in the instruction register
    always_comb begin
        case (opcode)
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_I;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            7'b1100011: cls_d = C_BRANCH;
            7'b1101111: cls_d = C_JAL;
            7'b1100111: cls_d = C_JALR;
            default:    cls_d = C_ILL;
        endcase
    end

    // next state and control outputs; everything is held at zero while reset is high
    always_comb begin
        state_d       = state_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.i_or_d    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        alu_op        = 2'b00;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        link          = 1'b0;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    if (cls_d == C_ILL) begin
`ifdef CTRL_TRAP_EN
                        state_d = TRAP;
`else
                        instr_retired = 1'b1;
                        state_d       = FETCH;
`endif
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    alu_src = (cls_q == C_R || cls_q == C_BRANCH) ? 1'b0 : 1'b1;
                    alu_op  = (cls_q == C_R) ? 2'b10 :
                              (cls_q == C_LOAD || cls_q == C_STORE) ? 2'b00 :
                              (cls_q == C_BRANCH) ? 2'b01 : 2'b11;
                    case (cls_q)
                        C_R, C_I:        state_d = WB;
                        C_LOAD, C_STORE: state_d = MEM;
                        C_BRANCH: begin
                            pc_write      = taken;
                            pc_src        = 2'b01;
                            instr_retired = 1'b1;
                            state_d       = FETCH;
                        end
                        C_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                            state_d  = WB;
                        end
                        C_JALR: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b11;
                            state_d  = WB;
                        end
                        default: state_d = FETCH;
                    endcase
                end
                MEM: begin
                    bus.mem_req = 1'b1;
                    bus.i_or_d  = 1'b1;
                    bus.mem_we  = (cls_q == C_STORE);
                    if (bus.mem_ready) begin
                        instr_retired = (cls_q == C_STORE);
                        state_d       = (cls_q == C_STORE) ? FETCH : WB;
                    end
                end
                WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = (cls_q == C_LOAD);
                    link          = (cls_q == C_JAL || cls_q == C_JALR);
                    instr_retired = 1'b1;
                    state_d       = FETCH;
                end
`ifdef CTRL_TRAP_EN
                TRAP:    state_d = TRAP;
`endif
                default: state_d = FETCH;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // instruction class is captured once in DECODE and reused by later states
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 cls_q <= C_R;
        else if (state_q == DECODE) cls_q <= cls_d;
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              retired <= '0;
        else if (instr_retired) retired <= retired + RETIRE_W'(1);
    end

    assign state = state_q;
`ifdef CTRL_TRAP_EN
    assign illegal = (state_q == TRAP);
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven check of the multi-cycle controller plus reset/illegal/wrap sequences
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       taken = 1'b0;
    logic       ir_write, pc_write, alu_src, mem_to_reg, link, reg_write, instr_retired, illegal;
    logic [1:0] pc_src, alu_op;
    logic [3:0] retired;
    logic [2:0] state;
    logic [13:0] ctl;
    int total = 0;
    int bad = 0;
    int step_no = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.RETIRE_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .opcode(opcode),
        .taken(taken),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .pc_src(pc_src),
        .alu_op(alu_op),
        .alu_src(alu_src),
        .mem_to_reg(mem_to_reg),
        .link(link),
        .reg_write(reg_write),
        .instr_retired(instr_retired),
        .retired(retired),
        .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    assign ctl = {bus.mem_req, bus.mem_we, bus.i_or_d, ir_write, pc_write, pc_src,
                  alu_op, alu_src, mem_to_reg, link, reg_write, instr_retired};

    localparam logic [13:0] REQ  = 14'h2000;
    localparam logic [13:0] WE   = 14'h1000;
    localparam logic [13:0] IOD  = 14'h0800;
    localparam logic [13:0] IRW  = 14'h0400;
    localparam logic [13:0] PCW  = 14'h0200;
    localparam logic [13:0] ASRC = 14'h0010;
    localparam logic [13:0] M2R  = 14'h0008;
    localparam logic [13:0] LNK  = 14'h0004;
    localparam logic [13:0] RW   = 14'h0002;
    localparam logic [13:0] IR   = 14'h0001;
    localparam logic [13:0] FOK  = REQ | IRW | PCW;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JL = 7'b1101111;
    localparam logic [6:0] OP_JR = 7'b1100111;
    localparam logic [6:0] OP_XX = 7'b0000000;

    function automatic logic [13:0] pcs(int n);
        return 14'(n) << 7;
    endfunction

    function automatic logic [13:0] aop(int n);
        return 14'(n) << 5;
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        tkn;
        logic [2:0]  st;
        logic [13:0] c;
        int          ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [6:0] op, logic rdy, logic tkn, logic [2:0] st, logic [13:0] c, int ret);
        vec_t r;
        r.op = op; r.rdy = rdy; r.tkn = tkn; r.st = st; r.c = c; r.ret = ret;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step_no, act, exp);
        end
    endtask

    task automatic drive(logic [6:0] op, logic rdy, logic tkn);
        opcode = op;
        bus.mem_ready = rdy;
        taken = tkn;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        step_no++;
    endtask

    task automatic expect_all(logic [2:0] st, logic [13:0] c, int ret, logic ill);
        chk("state", 32'(state), 32'(st));
        chk("ctl", 32'(ctl), 32'(c));
        chk("retired", 32'(retired), ret);
        chk("illegal", 32'(illegal), 32'(ill));
    endtask

    initial begin
        bus.mem_ready = 1'b1;
        // R
        tbl.push_back(v(OP_R, 1, 0, 0, FOK, 0));
        tbl.push_back(v(OP_R, 1, 0, 1, 0, 0));
        tbl.push_back(v(OP_R, 0, 0, 2, aop(2), 0));
        tbl.push_back(v(OP_R, 1, 0, 4, RW | IR, 0));
        // LOAD with three wait cycles in MEM
        tbl.push_back(v(OP_LD, 1, 0, 0, FOK, 1));
        tbl.push_back(v(OP_LD, 1, 0, 1, 0, 1));
        tbl.push_back(v(OP_LD, 1, 0, 2, aop(0) | ASRC, 1));
        tbl.push_back(v(OP_LD, 0, 0, 3, REQ | IOD, 1));
        tbl.push_back(v(OP_LD, 0, 0, 3, REQ | IOD, 1));
        tbl.push_back(v(OP_LD, 0, 0, 3, REQ | IOD, 1));
        tbl.push_back(v(OP_LD, 1, 0, 3, REQ | IOD, 1));
        tbl.push_back(v(OP_LD, 1, 0, 4, M2R | RW | IR, 1));
        // BRANCH taken, then not taken
        tbl.push_back(v(OP_BR, 1, 0, 0, FOK, 2));
        tbl.push_back(v(OP_BR, 1, 0, 1, 0, 2));
        tbl.push_back(v(OP_BR, 1, 1, 2, PCW | pcs(1) | aop(1) | IR, 2));
        tbl.push_back(v(OP_BR, 1, 0, 0, FOK, 3));
        tbl.push_back(v(OP_BR, 1, 0, 1, 0, 3));
        tbl.push_back(v(OP_BR, 1, 0, 2, pcs(1) | aop(1) | IR, 3));
        // JALR, mem_ready low in DECODE is ignored
        tbl.push_back(v(OP_JR, 1, 0, 0, FOK, 4));
        tbl.push_back(v(OP_JR, 0, 0, 1, 0, 4));
        tbl.push_back(v(OP_JR, 1, 0, 2, PCW | pcs(3) | aop(3) | ASRC, 4));
        tbl.push_back(v(OP_JR, 1, 0, 4, LNK | RW | IR, 4));
        // STORE with one FETCH wait cycle
        tbl.push_back(v(OP_ST, 0, 0, 0, REQ, 5));
        tbl.push_back(v(OP_ST, 1, 0, 0, FOK, 5));
        tbl.push_back(v(OP_ST, 1, 0, 1, 0, 5));
        tbl.push_back(v(OP_ST, 1, 0, 2, aop(0) | ASRC, 5));
        tbl.push_back(v(OP_ST, 1, 0, 3, REQ | WE | IOD | IR, 5));
        // I, mem_ready low in EXEC is ignored
        tbl.push_back(v(OP_I, 1, 0, 0, FOK, 6));
        tbl.push_back(v(OP_I, 1, 0, 1, 0, 6));
        tbl.push_back(v(OP_I, 0, 0, 2, aop(3) | ASRC, 6));
        tbl.push_back(v(OP_I, 1, 0, 4, RW | IR, 6));
        // JAL, taken is ignored outside a branch
        tbl.push_back(v(OP_JL, 1, 0, 0, FOK, 7));
        tbl.push_back(v(OP_JL, 1, 1, 1, 0, 7));
        tbl.push_back(v(OP_JL, 1, 1, 2, PCW | pcs(2) | aop(3) | ASRC, 7));
        tbl.push_back(v(OP_JL, 1, 0, 4, LNK | RW | IR, 7));
        tbl.push_back(v(OP_R, 0, 0, 0, REQ, 8));

        // reset held: everything zero even with mem_ready high
        #3;
        expect_all(3'd0, 14'd0, 0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].rdy, tbl[i].tkn);
            expect_all(tbl[i].st, tbl[i].c, tbl[i].ret, 1'b0);
            tick();
        end

        // illegal opcode
        drive(OP_XX, 1, 0);
        expect_all(3'd0, FOK, 8, 1'b0);
        tick();
        drive(OP_XX, 1, 0);
`ifdef CTRL_TRAP_EN
        expect_all(3'd1, 14'd0, 8, 1'b0);
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(OP_XX, k[0], k[1]);
            expect_all(3'd5, 14'd0, 8, 1'b1);
            tick();
        end
`else
        expect_all(3'd1, IR, 8, 1'b0);
        tick();
        drive(OP_R, 0, 0);
        expect_all(3'd0, REQ, 9, 1'b0);
        tick();
`endif

        // reset during MEM of a STORE abandons the request
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(OP_R, 1, 0);
        expect_all(3'd0, FOK, 0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(OP_R, 1, 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(OP_ST, 1, 0);
            tick();
        end
        drive(OP_ST, 0, 0);
        expect_all(3'd3, REQ | WE | IOD, 1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        expect_all(3'd0, 14'd0, 0, 1'b0);
        tick();
        reset = 1'b0;
        drive(OP_BR, 1, 0);
        expect_all(3'd0, FOK, 0, 1'b0);

        // 16 branches wrap the 4-bit counter
        for (int n = 0; n < 16; n++) begin
            drive(OP_BR, 1, 0);
            if (n == 15) chk("retired_all_ones", 32'(retired), 15);
            for (int k = 0; k < 3; k++) begin
                drive(OP_BR, 1, 0);
                tick();
            end
        end
        drive(OP_BR, 0, 0);
        expect_all(3'd0, REQ, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
